// File: rtl/iir_wb_master.sv
// iir_wb_master: Wishbone classic initiator that loads IIR coefficients and streams samples through the filter.
// Define IIR_MASTER_READBACK_EN to read back every coefficient and flag mismatches on err_o[1].
module iir_wb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_COEFFS = 15,
    parameter logic [ADDR_WIDTH-1:0] X_ADDR = 7'h3C,
    parameter logic [ADDR_WIDTH-1:0] Y_ADDR = 7'h40,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    input  logic                  wb_ack_i,
    input  logic                  cfg_load_i,
    output logic [3:0]            cfg_idx_o,
    input  logic [DATA_WIDTH-1:0] cfg_data_i,
    output logic                  cfg_busy_o,
    output logic                  cfg_done_o,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            err_o
);
    typedef enum logic [3:0] {IDLE, CFG_WR, CFG_GAP, CFG_RGAP, CFG_RD, SAMP_WR, SETTLE, SAMP_RD, OUT_HOLD} state_t;
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(4 * (NUM_COEFFS - 1));
    state_t state, state_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [ADDR_WIDTH-1:0] adr_n, cfg_adr;
    logic [DATA_WIDTH-1:0] dat_n, m_data_n;
    logic [3:0] idx_n, idx_inc;
    logic [1:0] err_n;
    logic we_n, stb_n, busy_n, done_n, s_ready_n, m_valid_n, timeout;
    assign cfg_adr = ADDR_WIDTH'({cfg_idx_o, 2'b00});
    // The index advances as soon as a coefficient finishes so cfg_data_i is valid during the gap
    assign idx_inc = (wb_adr_o == LAST_ADR) ? cfg_idx_o : cfg_idx_o + 4'd1;
    assign timeout = wb_stb_o && !wb_ack_i && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_comb begin
        state_n = state;
        settle_n = settle_cnt;
        tmo_n = wb_stb_o ? tmo_cnt + TW'(1) : tmo_cnt;
        adr_n = wb_adr_o;
        dat_n = wb_dat_o;
        we_n = wb_we_o;
        stb_n = wb_stb_o;
        idx_n = cfg_idx_o;
        busy_n = cfg_busy_o;
        done_n = 1'b0;
        s_ready_n = s_ready_o;
        m_valid_n = m_valid_o;
        m_data_n = m_data_o;
        err_n = err_o;
        case (state)
            IDLE: begin
                if (cfg_load_i) begin
                    state_n = CFG_WR;
                    busy_n = 1'b1;
                    s_ready_n = 1'b0;
                    stb_n = 1'b1;
                    we_n = 1'b1;
                    adr_n = cfg_adr;
                    dat_n = cfg_data_i;
                    tmo_n = '0;
                end else if (s_valid_i && s_ready_o) begin
                    state_n = SAMP_WR;
                    s_ready_n = 1'b0;
                    stb_n = 1'b1;
                    we_n = 1'b1;
                    adr_n = X_ADDR;
                    dat_n = s_data_i;
                    tmo_n = '0;
                end
            end
            CFG_WR: begin
                if (wb_ack_i) begin
                    stb_n = 1'b0;
`ifdef IIR_MASTER_READBACK_EN
                    state_n = CFG_RGAP;
`else
                    state_n = CFG_GAP;
                    idx_n = idx_inc;
`endif
                end
            end
`ifdef IIR_MASTER_READBACK_EN
            CFG_RGAP: begin
                state_n = CFG_RD;
                stb_n = 1'b1;
                we_n = 1'b0;
                tmo_n = '0;
            end
            CFG_RD: begin
                if (wb_ack_i) begin
                    stb_n = 1'b0;
                    state_n = CFG_GAP;
                    idx_n = idx_inc;
                    err_n[1] = err_o[1] | (wb_dat_i != wb_dat_o);
                end
            end
`endif
            CFG_GAP: begin
                if (wb_adr_o == LAST_ADR) begin
                    state_n = IDLE;
                    done_n = 1'b1;
                    busy_n = 1'b0;
                    idx_n = '0;
                    s_ready_n = 1'b1;
                end else begin
                    state_n = CFG_WR;
                    stb_n = 1'b1;
                    we_n = 1'b1;
                    adr_n = cfg_adr;
                    dat_n = cfg_data_i;
                    tmo_n = '0;
                end
            end
            SAMP_WR: begin
                if (wb_ack_i) begin
                    stb_n = 1'b0;
                    state_n = SETTLE;
                    settle_n = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    state_n = SAMP_RD;
                    stb_n = 1'b1;
                    we_n = 1'b0;
                    adr_n = Y_ADDR;
                    tmo_n = '0;
                end else begin
                    settle_n = settle_cnt + SW'(1);
                end
            end
            SAMP_RD: begin
                if (wb_ack_i) begin
                    stb_n = 1'b0;
                    state_n = OUT_HOLD;
                    m_data_n = wb_dat_i;
                    m_valid_n = 1'b1;
                end
            end
            OUT_HOLD: begin
                if (m_ready_i) begin
                    m_valid_n = 1'b0;
                    s_ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A stalled slave abandons whatever was in flight, sample or coefficient load
        if (timeout) begin
            state_n = IDLE;
            stb_n = 1'b0;
            err_n[0] = 1'b1;
            busy_n = 1'b0;
            idx_n = '0;
            done_n = 1'b0;
            s_ready_n = 1'b1;
        end
`ifndef IIR_MASTER_READBACK_EN
        err_n[1] = 1'b0;
`endif
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            settle_cnt <= '0;
            tmo_cnt <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            cfg_idx_o <= '0;
            cfg_busy_o <= 1'b0;
            cfg_done_o <= 1'b0;
            s_ready_o <= 1'b0;
            m_valid_o <= 1'b0;
            m_data_o <= '0;
            err_o <= '0;
        end else begin
            state <= state_n;
            settle_cnt <= settle_n;
            tmo_cnt <= tmo_n;
            wb_adr_o <= adr_n;
            wb_dat_o <= dat_n;
            wb_we_o <= we_n;
            wb_stb_o <= stb_n;
            wb_cyc_o <= stb_n;
            cfg_idx_o <= idx_n;
            cfg_busy_o <= busy_n;
            cfg_done_o <= done_n;
            s_ready_o <= state_n == IDLE ? 1'b1 : s_ready_n;
            m_valid_o <= m_valid_n;
            m_data_o <= m_data_n;
            err_o <= err_n;
        end
    end
endmodule

// File: doc/iir_wb_master.md
Name: iir_wb_master

Overview:
- Wishbone classic initiator that drives the IIR filter peripheral's slave port.
- Loads the 15 biquad coefficients from an external table on command.
- Converts a valid/ready sample stream into Wishbone transfers: write X, wait for the filter to settle, read Y.
- Returns each filtered result on a valid/ready output stream. Sits between the sample source (ADC or DMA) and the filter peripheral.

Parameters:
- DATA_WIDTH, 32, Wishbone data width and sample width.
- ADDR_WIDTH, 7, Wishbone address width (must hold 0x40).
- NUM_COEFFS, 15, coefficient words written per load, at byte addresses 4*idx.
- X_ADDR, 7'h3C, filter input register address.
- Y_ADDR, 7'h40, filter output register address.
- SETTLE_CYCLES, 2, idle cycles between the X-write ack and the Y-read strobe; minimum 1.
- TIMEOUT_CYCLES, 255, maximum cycles of asserted stb without ack.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_adr_o  out  ADDR_WIDTH  Wishbone address
- wb_dat_o  out  DATA_WIDTH  write data
- wb_dat_i  in  DATA_WIDTH  read data
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  acknowledge
- cfg_load_i  in  1  start coefficient load; sampled in IDLE only
- cfg_idx_o  out  4  coefficient table index
- cfg_data_i  in  DATA_WIDTH  table word for cfg_idx_o; combinational from cfg_idx_o
- cfg_busy_o  out  1  coefficient load in progress
- cfg_done_o  out  1  one-cycle pulse when the load completes
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  input sample ready
- s_data_i  in  DATA_WIDTH  input sample
- m_valid_o  out  1  result valid
- m_ready_i  in  1  result ready
- m_data_o  out  DATA_WIDTH  filtered result (raw wb_dat_i)
- err_o  out  2  sticky errors: bit0 = ack timeout, bit1 = readback mismatch

Behaviour:
- All outputs are registered. Reset value of every output is 0, including cfg_idx_o and err_o. FSM resets to IDLE.
- FSM states: IDLE, CFG_WR, CFG_GAP, SAMP_WR, SETTLE, SAMP_RD, OUT_HOLD.
- Bus access rules:
  - Entering an access state sets cyc/stb and drives adr/dat/we.
  - Signals hold until wb_ack_i is sampled high at an edge; that edge clears cyc/stb.
  - cyc/stb are low for at least one cycle between accesses.
  - The timeout counter resets at each access start.
- IDLE:
  - s_ready_o = 1 unless cfg_load_i = 1.
  - cfg_load_i has priority: it goes to CFG_WR with idx = 0 and sets cfg_busy_o.
  - Otherwise, an s_valid_i/s_ready_o handshake latches s_data_i and goes to SAMP_WR.
  - cfg_load_i outside IDLE is ignored.
- CFG_WR:
  - adr = 4*idx, we = 1, dat = cfg_data_i sampled at the launching edge.
  - On ack, go to CFG_GAP.
- CFG_GAP: one idle cycle, then:
  - if idx < NUM_COEFFS-1: idx+1, back to CFG_WR;
  - else: pulse cfg_done_o, clear cfg_busy_o and idx, go to IDLE.
- SAMP_WR: adr = X_ADDR, we = 1. On ack, go to SETTLE.
- SETTLE: SETTLE_CYCLES idle cycles, then SAMP_RD.
- SAMP_RD: adr = Y_ADDR, we = 0. On ack, capture wb_dat_i into m_data_o, set m_valid_o, go to OUT_HOLD.
- OUT_HOLD:
  - m_data_o is stable while m_valid_o && !m_ready_i.
  - The handshake clears m_valid_o and returns to IDLE.
  - Only one sample is in flight.
- Latency: with a slave that acks one cycle after stb, m_valid_o rises at the (4+SETTLE_CYCLES)th edge after the accepting edge (6 at defaults).
- Timeout:
  - Condition: stb high with no ack for TIMEOUT_CYCLES cycles.
  - Action: clear cyc/stb, set err_o[0], go to IDLE.
  - The in-flight sample is dropped with no output; a load in progress aborts without a cfg_done_o pulse.
- err_o bits clear only on reset.
- Reset mid-operation: the next edge returns all outputs to 0 and abandons the transfer; no partial outputs.

Optional Feature:
IIR_MASTER_READBACK_EN
- Defined: after each CFG_WR ack, one gap cycle, then a read of the same address (CFG_RD). On a data mismatch, set err_o[1]; the load continues. CFG_GAP follows the read. Each coefficient takes 2 accesses.
- Undefined: no readback; err_o[1] is tied to 0.

Test Plan:
- Table word = 16*idx+1, pulse cfg_load_i -> 15 writes at adr 0x00..0x38 with data 0x01,0x11..0xE1; cfg_done_o pulses once; cfg_busy_o high throughout; err_o = 0.
- s_data_i = 0x00001000, model slave returns Y = 0xDEADBEEF -> write 0x3C/0x1000, 2 idle cycles, read 0x40; m_data_o = 0xDEADBEEF with m_valid_o at edge 6.
- m_ready_i held low 10 cycles after result -> m_data_o stable, s_ready_o = 0; accepts the next sample only after the handshake.
- Slave never acks the X write -> stb drops after 255 cycles, err_o = 2'b01, no m_valid_o, s_ready_o = 1 next cycle.
- wb_rst_i asserted during load at idx 7 -> next edge cyc/stb/cfg_busy_o/cfg_idx_o = 0, FSM in IDLE, no cfg_done_o.
- With IIR_MASTER_READBACK_EN, slave corrupts readback of idx 3 -> err_o[1] = 1, all 15 writes still issued, cfg_done_o pulses.
